// File: rtl/spi_reg_ctrl.sv
// Command/register controller that sits on a byte-level SPI slave interface.
// The first byte of each SS frame is a command: bit7 selects read (1) or write (0),
// and bits 6:0 give the start address. The address auto-increments for each
// following byte and wraps from 127 to 0.
//
// state | meaning
// IDLE  | no frame in progress; wait for the synchronized SS falling edge
// CMD   | frame open; the next received byte is the command
// WR    | each received byte is written to reg[addr] (writes are dropped when addr >= NREGS)
// RD    | each received byte is a dummy; tx is loaded with reg[addr] for the next byte
module spi_reg_ctrl #(
  parameter int         NREGS       = 16,
  parameter logic [7:0] STATUS_BYTE = 8'h5A
) (
  input  logic                 sysClk,
  input  logic                 usrReset,
  input  logic                 SS,
  input  logic                 rxValid,
  input  logic [7:0]           rx,
  output logic [7:0]           tx,
  output logic                 regWr,
  output logic [6:0]           regWrAddr,
  output logic [NREGS*8-1:0]   regsFlat,
  output logic                 frameActive
);

  typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

  state_t      state, state_n;
  logic        ss_meta, ss_sync, ss_prev;
  logic        ss_fall, ss_rise;
  logic [6:0]  addr, addr_n;
  logic [7:0]  tx_n;
  logic        wr_en;
  logic        in_range;
  logic [6:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [7:0]  regs [NREGS];

  // Bring SS into the sysClk domain and keep one extra flop for edge detection.
  // The flops reset to 0 (selected), so a reset taken mid-frame cannot produce
  // a falling edge until SS has gone high and then low again.
  always_ff @(posedge sysClk) begin
    if (usrReset) begin
      ss_meta <= 1'b0;
      ss_sync <= 1'b0;
      ss_prev <= 1'b0;
    end else begin
      ss_meta <= SS;
      ss_sync <= ss_meta;
      ss_prev <= ss_sync;
    end
  end

  assign ss_fall = ss_prev & ~ss_sync;
  assign ss_rise = ~ss_prev & ss_sync;

  // A read of a command byte uses the address carried in that byte; otherwise
  // the running address is used.
  assign rd_addr = (state == CMD) ? rx[6:0] : addr;

  // Read mux and write range check; out-of-range addresses read back as zero.
  always_comb begin
    rd_data  = 8'h00;
    in_range = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (rd_addr == 7'(i)) rd_data = regs[i];
      if (addr == 7'(i)) in_range = 1'b1;
    end
  end

  // Next-state and datapath decisions; an SS rise overrides state and tx but
  // still lets a byte received in the same cycle take effect.
  always_comb begin
    state_n = state;
    tx_n    = tx;
    addr_n  = addr;
    wr_en   = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_n = CMD;
          tx_n    = STATUS_BYTE;
        end
      end
      CMD: begin
        if (rxValid) begin
          if (rx[7]) begin
            state_n = RD;
            tx_n    = rd_data;
            addr_n  = rx[6:0] + 7'd1;
          end else begin
            state_n = WR;
            tx_n    = 8'h00;
            addr_n  = rx[6:0];
          end
        end
      end
      WR: begin
        if (rxValid) begin
          wr_en  = in_range;
          addr_n = addr + 7'd1;
        end
      end
      RD: begin
        if (rxValid) begin
          tx_n   = rd_data;
          addr_n = addr + 7'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state != IDLE && ss_rise) begin
      state_n = IDLE;
      tx_n    = STATUS_BYTE;
    end
  end

  // State, address, tx and status outputs.
  always_ff @(posedge sysClk) begin
    if (usrReset) begin
      state       <= IDLE;
      addr        <= 7'd0;
      tx          <= STATUS_BYTE;
      regWr       <= 1'b0;
      regWrAddr   <= 7'd0;
      frameActive <= 1'b0;
    end else begin
      state       <= state_n;
      addr        <= addr_n;
      tx          <= tx_n;
      regWr       <= wr_en;
      regWrAddr   <= wr_en ? addr : regWrAddr;
      frameActive <= (state_n != IDLE);
    end
  end

  // Register file storage.
  always_ff @(posedge sysClk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (usrReset) regs[i] <= 8'h00;
      else if (wr_en && addr == 7'(i)) regs[i] <= rx;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regsFlat[8*g +: 8] = regs[g];
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: a frame table plus hand-written corner sequences.
// Expected MISO bytes and expected register writes are queued when a frame is
// driven, and they are popped as the DUT produces tx bytes and regWr pulses.
module tb_spi_reg_ctrl;
  localparam int NREGS = 16;

  logic               sysClk = 1'b0;
  logic               usrReset;
  logic               SS;
  logic               rxValid;
  logic [7:0]         rx;
  logic [7:0]         tx;
  logic               regWr;
  logic [6:0]         regWrAddr;
  logic [NREGS*8-1:0] regsFlat;
  logic               frameActive;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  miso_q [$];
  logic [14:0] wr_q   [$];
  logic [7:0]  model  [NREGS];

  spi_reg_ctrl #(.NREGS(NREGS), .STATUS_BYTE(8'h5A)) dut (
    .sysClk(sysClk), .usrReset(usrReset), .SS(SS), .rxValid(rxValid), .rx(rx),
    .tx(tx), .regWr(regWr), .regWrAddr(regWrAddr), .regsFlat(regsFlat),
    .frameActive(frameActive)
  );

  always #5 sysClk = ~sysClk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Each regWr pulse is compared with the oldest expected write.
  always @(negedge sysClk) begin
    if (!usrReset && regWr) begin
      if (wr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%0h data=%0h", regWrAddr, regsFlat[8*regWrAddr +: 8]);
      end else begin
        logic [14:0] e;
        e = wr_q.pop_front();
        check("regWr_addr_data", {regWrAddr, regsFlat[8*regWrAddr +: 8]}, e);
      end
    end
  end

  function automatic logic [NREGS*8-1:0] model_flat();
    logic [NREGS*8-1:0] f;
    for (int i = 0; i < NREGS; i++) f[8*i +: 8] = model[i];
    return f;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge sysClk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge sysClk); #1;
    rx = b; rxValid = 1'b1;
    @(posedge sysClk); #1;
    rxValid = 1'b0; rx = 8'h00;
    cycles(3);
  endtask

  // The byte shifted out on MISO is whatever tx holds when the byte starts.
  task automatic shift_byte(input logic [7:0] b);
    @(negedge sysClk);
    if (miso_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL miso_queue_empty actual=%0h", tx);
    end else begin
      logic [7:0] e;
      e = miso_q.pop_front();
      check("miso_byte", tx, e);
    end
    send_byte(b);
  endtask

  task automatic ss_low();
    @(posedge sysClk); #1; SS = 1'b0;
    cycles(5);
  endtask

  task automatic ss_high();
    @(posedge sysClk); #1; SS = 1'b1;
    cycles(5);
  endtask

  // Predict writes from the reference model for a write frame.
  task automatic model_writes(input logic [7:0] cmd, input int n, input logic [3:0][7:0] d);
    logic [6:0] a;
    a = cmd[6:0];
    for (int k = 0; k < n; k++) begin
      if (int'(a) < NREGS) begin
        wr_q.push_back({a, d[k]});
        model[a[3:0]] = d[k];
      end
      a = a + 7'd1;
    end
  endtask

  typedef struct {
    logic [7:0]       cmd;
    int               n;
    logic [3:0][7:0]  data;
    logic [4:0][7:0]  miso;
  } frame_t;

  frame_t frames [7];

  initial begin
    frames[0] = '{cmd: 8'h03, n: 2, data: {8'h00, 8'h00, 8'hBB, 8'hAA}, miso: {8'h00, 8'h00, 8'h00, 8'h00, 8'h5A}};
    frames[1] = '{cmd: 8'h83, n: 3, data: {8'h00, 8'hFF, 8'hFF, 8'hFF}, miso: {8'h00, 8'h00, 8'hBB, 8'hAA, 8'h5A}};
    frames[2] = '{cmd: 8'h0F, n: 2, data: {8'h00, 8'h00, 8'h22, 8'h11}, miso: {8'h00, 8'h00, 8'h00, 8'h00, 8'h5A}};
    frames[3] = '{cmd: 8'h8F, n: 2, data: {8'h00, 8'h00, 8'hFF, 8'hFF}, miso: {8'h00, 8'h00, 8'h00, 8'h11, 8'h5A}};
    frames[4] = '{cmd: 8'h7F, n: 2, data: {8'h00, 8'h00, 8'h02, 8'h01}, miso: {8'h00, 8'h00, 8'h00, 8'h00, 8'h5A}};
    frames[5] = '{cmd: 8'h80, n: 2, data: {8'h00, 8'h00, 8'hFF, 8'hFF}, miso: {8'h00, 8'h00, 8'h00, 8'h02, 8'h5A}};
    frames[6] = '{cmd: 8'h8E, n: 3, data: {8'h00, 8'hFF, 8'hFF, 8'hFF}, miso: {8'h00, 8'h00, 8'h11, 8'h00, 8'h5A}};

    for (int i = 0; i < NREGS; i++) model[i] = 8'h00;
    usrReset = 1'b1; SS = 1'b1; rxValid = 1'b0; rx = 8'h00;
    @(negedge sysClk);
    check("reset_tx", tx, 8'h5A);
    check("reset_regWr", regWr, 1'b0);
    check("reset_regWrAddr", regWrAddr, 7'd0);
    check("reset_frameActive", frameActive, 1'b0);
    check("reset_regs", regsFlat, '0);
    cycles(2);
    usrReset = 1'b0;
    cycles(5);

    // Table-driven frames.
    for (int f = 0; f < 7; f++) begin
      if (!frames[f].cmd[7]) model_writes(frames[f].cmd, frames[f].n, frames[f].data);
      for (int k = 0; k <= frames[f].n; k++) miso_q.push_back(frames[f].miso[k]);
      ss_low();
      check("frame_active_in", frameActive, 1'b1);
      shift_byte(frames[f].cmd);
      for (int k = 0; k < frames[f].n; k++) shift_byte(frames[f].data[k]);
      ss_high();
      check("frame_active_out", frameActive, 1'b0);
      check("idle_tx", tx, 8'h5A);
      check("regs_after_frame", regsFlat, model_flat());
    end

    // Bytes outside a frame and a frame closed before its command byte.
    send_byte(8'h09);
    ss_low();
    ss_high();
    check("empty_frame_regs", regsFlat, model_flat());
    check("empty_frame_idle", frameActive, 1'b0);

    // Reset in the middle of a write frame with SS held low.
    ss_low();
    model_writes(8'h01, 1, {8'h00, 8'h00, 8'h00, 8'h33});
    send_byte(8'h01);
    send_byte(8'h33);
    check("pre_reset_write", regsFlat[15:8], 8'h33);
    @(posedge sysClk); #1; usrReset = 1'b1;
    @(posedge sysClk); #1; usrReset = 1'b0;
    for (int i = 0; i < NREGS; i++) model[i] = 8'h00;
    send_byte(8'h01);
    send_byte(8'h44);
    send_byte(8'h55);
    check("post_reset_regs_zero", regsFlat, '0);
    check("post_reset_idle", frameActive, 1'b0);
    check("post_reset_tx", tx, 8'h5A);
    ss_high();
    ss_low();
    model_writes(8'h05, 1, {8'h00, 8'h00, 8'h00, 8'h66});
    send_byte(8'h05);
    send_byte(8'h66);
    ss_high();
    check("frame_after_reset", regsFlat, model_flat());

    // A byte arriving in the same cycle as the synchronized SS rise.
    ss_low();
    send_byte(8'h02);
    model_writes(8'h02, 1, {8'h00, 8'h00, 8'h00, 8'h77});
    @(posedge sysClk); #1; SS = 1'b1;
    @(posedge sysClk);
    @(posedge sysClk); #1; rx = 8'h77; rxValid = 1'b1;
    @(posedge sysClk); #1; rxValid = 1'b0; rx = 8'h00;
    check("rise_same_cycle_idle", frameActive, 1'b0);
    check("rise_same_cycle_tx", tx, 8'h5A);
    cycles(3);
    check("rise_same_cycle_reg2", regsFlat[23:16], 8'h77);
    check("final_regs", regsFlat, model_flat());

    check("writes_outstanding", wr_q.size(), 0);
    check("miso_outstanding", miso_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Command/register controller on top of the `spi_slave_byte` byte interface.
- Decodes the first byte of each SS frame as a command (read or write plus start address) and moves subsequent bytes into or out of a local 8-bit register file, with address auto-increment.
- Drives the byte interface `tx` so the next read byte is ready before the next SPI byte starts shifting.
- Exposes register contents and write strobes to the rest of the FPGA fabric.

Parameters:
- NREGS, 16, number of implemented 8-bit registers (1..128).
- STATUS_BYTE, 8'h5A, value shifted out on MISO during the command byte.

Ports:
- sysClk  in  1  system clock; all logic on its rising edge.
- usrReset  in  1  synchronous, active-high reset.
- SS  in  1  raw SPI slave select, active low, asynchronous to sysClk.
- rxValid  in  1  one-sysClk pulse from the byte interface: `rx` holds a complete received byte.
- rx  in  8  received byte; valid only when rxValid=1.
- tx  out  8  byte the byte interface shifts out next.
- regWr  out  1  one-cycle pulse when a register is written from SPI.
- regWrAddr  out  7  address of the register written; valid with regWr.
- regsFlat  out  NREGS*8  register file; reg i = regsFlat[8i+7:8i].
- frameActive  out  1  high while the FSM is in CMD, WR or RD.

Behaviour:
- Reset values (sysClk cycle where usrReset=1):
  - all registers 8'h00; tx=STATUS_BYTE; regWr=0; regWrAddr=0; state=IDLE; addr=0; frameActive=0.
  - SS synchronizer flops reset to 0 (i.e. selected).
- SS sync: 2-flop synchronizer, then edge detect.
  - ssFall = previous synced value 1, current 0.
  - ssRise = previous synced value 0, current 1.
  - Consequence: reset asserted mid-frame leaves the FSM in IDLE until SS goes high, then low again. A partial frame is never decoded.
- Command byte:
  - bit7 = 1 means read, 0 means write.
  - bits6:0 = start address.
- FSM states: IDLE, CMD, WR, RD.
  - IDLE: on ssFall go to CMD and set tx<=STATUS_BYTE. rxValid is ignored.
  - CMD, on rxValid:
    - addr<=rx[6:0].
    - If rx[7]=0: go to WR, tx<=8'h00.
    - If rx[7]=1: go to RD, tx<=rd(rx[6:0]), addr<=rx[6:0]+1.
  - WR, on rxValid:
    - If addr<NREGS: reg[addr]<=rx, regWr=1 for one cycle, regWrAddr=addr.
    - If addr>=NREGS: write dropped, regWr stays 0.
    - Always addr<=addr+1; tx stays 8'h00.
  - RD, on rxValid:
    - tx<=rd(addr), addr<=addr+1.
    - The received (dummy) byte is discarded.
  - CMD/WR/RD: on ssRise go to IDLE and set tx<=STATUS_BYTE.
- rd(a): reg[a] if a<NREGS, else 8'h00.
- Latency: tx is updated on the sysClk edge after the rxValid cycle (1 cycle). It is held stable until the next update. sysClk must be ≥8× SCLK, so tx is ready before the next byte's first shift edge.
- Read ordering: a read of N data bytes returns reg[A], reg[A+1], …; the value is captured at the rxValid of the preceding byte.
- Address arithmetic: 7-bit, wraps 127→0. In-range is checked per byte, so a burst can cross NREGS into the dropped/zero region and wrap back to 0.
- Simultaneous events:
  - rxValid and ssRise in the same cycle: the byte is processed (write or addr advance) and the FSM goes to IDLE in that same cycle. tx ends at STATUS_BYTE, because ssRise takes priority for tx.
  - rxValid and ssFall in the same cycle, from IDLE: the byte is ignored.
- Zero-data frames:
  - A frame containing only a command byte changes no registers.
  - A frame ended before the command byte completes returns to IDLE with no effect.
- frameActive = (state != IDLE), registered.

Test Plan:
1. Reset, then SS low, send 8'h03 then 8'hAA, 8'hBB, then SS high → reg3=AA and reg4=BB; two regWr pulses with regWrAddr 3 then 4; MISO during the command byte = 8'h5A.
2. After scenario 1: SS low, send 8'h83 plus 3 dummy bytes → MISO bytes are 5A, AA, BB, 00; no regWr pulses.
3. NREGS=16: write command 8'h0F with data 11, 22 → reg15=11, 22 dropped (one regWr only). Read command 8'h8F plus 2 dummies → MISO 5A, 11, 00.
4. Write command 8'h7F with data 01, 02 → address 127 dropped, wraps so reg0=02; regWrAddr=0 on the single pulse.
5. Assert usrReset for 1 cycle mid-write-frame with SS held low, then keep sending bytes → no writes occur, regs all 00. After SS high→low, the next frame is decoded normally.
6. Force rxValid in the same cycle the synced SS rise appears, in WR at addr 2 with rx=8'h77 → reg2=77, state IDLE next cycle, tx=8'h5A.
